// File: rtl/swervolf_sevseg_ctrl.sv
// Wishbone-mapped multiplexed 7-segment controller: per-digit enable, blink, decimal point,
// hex or raw segment mode and PWM brightness, driving common-anode digits with active-low pins.
module swervolf_sevseg_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_LOG2 = 14,
    parameter int BLINK_LOG2   = 25
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [4:0]          i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    output logic [N_DIGITS-1:0] o_an,
    output logic [6:0]          o_seg,
    output logic                o_dp
);

    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                  en_q;
    logic                  hex_q;
    logic [7:0]            bright_q;
    logic [N_DIGITS-1:0]   digit_en_q;
    logic [N_DIGITS-1:0]   blink_q;
    logic [8*N_DIGITS-1:0] data_q;
    logic [REFRESH_LOG2-1:0] slot_cnt;
    logic [BLINK_LOG2-1:0] blink_cnt;
    logic [DW-1:0]         digit;

    logic                  req;
    logic                  wr;
    logic [2:0]            word;
    logic [31:0]           rdata;
    logic                  unused_adr;

    logic [7:0]            cur_p0;
    logic [N_DIGITS-1:0]   onehot_p0;
    logic [7:0]            slot_top_p0;
    logic                  phase_p0;
    logic                  pwm_on_p0;
    logic                  lit_p0;
    logic [6:0]            pat_p0;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign req        = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr         = req & i_wb_we;
    assign word       = i_wb_adr[4:2];
    assign unused_adr = ^i_wb_adr[1:0];

    // Read mux: bytes of digits beyond N_DIGITS and unmapped bits stay zero
    always_comb begin
        rdata = '0;
        case (word)
            3'd0: rdata = {16'd0, bright_q, 6'd0, hex_q, en_q};
            3'd1: rdata[N_DIGITS-1:0] = digit_en_q;
            3'd2: rdata[N_DIGITS-1:0] = blink_q;
            3'd3: rdata[4:0] = {blink_cnt[BLINK_LOG2-1], 4'(digit)};
            default: begin
                for (int k = 0; k < N_DIGITS; k++) begin
                    if (word == 3'(4 + k / 4))
                        rdata[8*(k%4) +: 8] = data_q[8*k +: 8];
                end
            end
        endcase
    end

    // Stage p0: select the current digit and decide whether it is lit
    always_comb begin
        cur_p0    = '0;
        onehot_p0 = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (digit == DW'(k)) begin
                cur_p0       = data_q[8*k +: 8];
                onehot_p0[k] = 1'b1;
            end
        end
    end

    assign slot_top_p0 = slot_cnt[REFRESH_LOG2-1 -: 8];
    assign phase_p0    = blink_cnt[BLINK_LOG2-1];
    assign pwm_on_p0   = (bright_q == 8'hFF) || (slot_top_p0 < bright_q);
    assign lit_p0      = en_q & digit_en_q[digit] & pwm_on_p0 & ~(blink_q[digit] & phase_p0);
    assign pat_p0      = hex_q ? hex_decode(cur_p0[3:0]) : cur_p0[6:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            en_q       <= 1'b0;
            hex_q      <= 1'b0;
            bright_q   <= '0;
            digit_en_q <= '0;
            blink_q    <= '0;
            data_q     <= '0;
            slot_cnt   <= '0;
            blink_cnt  <= '0;
            digit      <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_rdt   <= '0;
            o_an       <= '1;
            o_seg      <= 7'h7F;
            o_dp       <= 1'b1;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (&slot_cnt)
                digit <= (digit == DW'(N_DIGITS - 1)) ? '0 : digit + 1'b1;

            o_wb_ack <= req;
            if (req)
                o_wb_rdt <= rdata;

            if (wr) begin
                case (word)
                    3'd0: begin
                        if (i_wb_sel[0]) {hex_q, en_q} <= i_wb_dat[1:0];
                        if (i_wb_sel[1]) bright_q <= i_wb_dat[15:8];
                    end
                    3'd1: begin
                        for (int b = 0; b < N_DIGITS; b++)
                            if (i_wb_sel[b/8]) digit_en_q[b] <= i_wb_dat[b];
                    end
                    3'd2: begin
                        for (int b = 0; b < N_DIGITS; b++)
                            if (i_wb_sel[b/8]) blink_q[b] <= i_wb_dat[b];
                    end
                    default: ;
                endcase
                for (int k = 0; k < N_DIGITS; k++) begin
                    if (word == 3'(4 + k / 4) && i_wb_sel[k%4])
                        data_q[8*k +: 8] <= i_wb_dat[8*(k%4) +: 8];
                end
            end

            // Stage p1: registered pins
            if (lit_p0) begin
                o_an  <= ~onehot_p0;
                o_seg <= ~pat_p0;
                o_dp  <= ~cur_p0[7];
            end else begin
                o_an  <= '1;
                o_seg <= 7'h7F;
                o_dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_swervolf_sevseg_ctrl.sv
// Directed bench for swervolf_sevseg_ctrl (6 digits, 256-clock slots, 1024-clock blink period):
// bus responses go through an expected-value queue checked by an ack monitor; pins are checked at chosen clocks.
module tb_swervolf_sevseg_ctrl;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [N-1:0] an;
    logic [6:0]  seg;
    logic        dp;

    int n_vec = 0;
    int n_err = 0;
    int tcount = 0;
    logic prev_ack = 1'b0;

    typedef struct packed {
        logic        rd;
        logic [4:0]  adr;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    swervolf_sevseg_ctrl #(
        .N_DIGITS(N),
        .REFRESH_LOG2(8),
        .BLINK_LOG2(10)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_wb_adr(wb_adr),
        .i_wb_dat(wb_dat),
        .i_wb_sel(wb_sel),
        .i_wb_we(wb_we),
        .i_wb_cyc(wb_cyc),
        .i_wb_stb(wb_stb),
        .o_wb_rdt(wb_rdt),
        .o_wb_ack(wb_ack),
        .o_an(an),
        .o_seg(seg),
        .o_dp(dp)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; equals the DUT's free-running counter value
    always @(posedge clk) begin
        if (!rst_n) tcount <= 0;
        else        tcount <= tcount + 1;
    end

    // Monitor: every ack pops one expected response
    always @(negedge clk) begin
        if (wb_ack) begin
            exp_t e;
            n_vec++;
            if (prev_ack) begin
                n_err++;
                $display("FAIL ack_pulse: ack high on two consecutive cycles, required single-cycle");
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ack_unexpected: ack=1 with no request outstanding, required 0");
            end else begin
                e = exp_q.pop_front();
                if (e.rd && wb_rdt !== e.exp) begin
                    n_err++;
                    $display("FAIL read adr=%02h: got %08h required %08h", e.adr, wb_rdt, e.exp);
                end
            end
        end
        prev_ack = wb_ack;
    end

    task automatic wait_until(input int t);
        int guard = 0;
        while (tcount < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (tcount != t) begin
            n_vec++;
            n_err++;
            $display("FAIL timing: clock count %0d, required %0d", tcount, t);
        end
    endtask

    task automatic bus_core(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [31:0] exp);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = we;
        wb_adr = adr;
        wb_dat = dat;
        wb_sel = sel;
        exp_q.push_back('{rd: ~we, adr: adr, exp: exp});
        @(posedge clk);
        #1;
        n_vec++;
        if (wb_ack !== 1'b1) begin
            n_err++;
            $display("FAIL ack_latency adr=%02h: ack=%b one cycle after request, required 1", adr, wb_ack);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(posedge clk);
    endtask

    task automatic bus_now(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp);
        @(negedge clk);
        bus_core(we, adr, dat, sel, exp);
    endtask

    task automatic bus_at(input int t, input logic we, input logic [4:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp);
        wait_until(t);
        bus_core(we, adr, dat, sel, exp);
    endtask

    // Pins seen at count c+1 reflect counters and registers at count c
    task automatic check_pins(input int c, input logic [N-1:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input string nm);
        wait_until(c + 1);
        n_vec++;
        if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
            n_err++;
            $display("FAIL %s @%0d: an=%02h seg=%02h dp=%b required an=%02h seg=%02h dp=%b",
                     nm, c, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    task automatic check_reset_pins(input string nm);
        n_vec++;
        if ({wb_ack, an, seg, dp} !== {1'b0, 6'h3F, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL %s: ack=%b an=%02h seg=%02h dp=%b required ack=0 an=3f seg=7f dp=1",
                     nm, wb_ack, an, seg, dp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_pins("reset_initial");
        rst_n = 1'b1;

        // Setup: hex mode, full brightness, digit 0 enabled, data bytes 0..5
        bus_now(1'b1, 5'h00, 32'h0000_FF03, 4'hF, 32'h0);
        bus_now(1'b1, 5'h04, 32'h0000_0001, 4'hF, 32'h0);
        bus_now(1'b1, 5'h10, 32'h0302_018A, 4'hF, 32'h0);
        bus_now(1'b1, 5'h14, 32'hAABB_0504, 4'hF, 32'h0);
        bus_now(1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0);
        bus_now(1'b0, 5'h00, 32'h0, 4'hF, 32'h0000_FF03);
        bus_now(1'b0, 5'h04, 32'h0, 4'hF, 32'h0000_0001);
        bus_now(1'b0, 5'h08, 32'h0, 4'hF, 32'h0000_0000);
        bus_now(1'b0, 5'h10, 32'h0, 4'hF, 32'h0302_018A);
        bus_now(1'b0, 5'h14, 32'h0, 4'hF, 32'h0000_0504);
        bus_now(1'b0, 5'h0C, 32'h0, 4'hF, 32'h0000_0000);
        bus_now(1'b0, 5'h18, 32'h0, 4'hF, 32'h0000_0000);
        bus_now(1'b0, 5'h1C, 32'h0, 4'hF, 32'h0000_0000);

        // Hex decode of 'A' with decimal point on digit 0; digit 1 disabled
        check_pins(100, 6'h3E, 7'h08, 1'b0, "hex_a_digit0");
        check_pins(300, 6'h3F, 7'h7F, 1'b1, "digit1_disabled");

        // Enable all digits; bits beyond N_DIGITS are dropped
        bus_at(400, 1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF, 32'h0);
        bus_now(1'b0, 5'h04, 32'h0, 4'hF, 32'h0000_003F);

        // Scan through digits and across the index wrap
        check_pins(640,  6'h3B, 7'h24, 1'b1, "scan_digit2");
        check_pins(896,  6'h37, 7'h30, 1'b1, "scan_digit3");
        check_pins(1152, 6'h2F, 7'h19, 1'b1, "scan_digit4");
        bus_at(1300, 1'b0, 5'h0C, 32'h0, 4'hF, 32'h0000_0005);
        check_pins(1408, 6'h1F, 7'h12, 1'b1, "scan_digit5");
        check_pins(1535, 6'h1F, 7'h12, 1'b1, "scan_digit5_last");
        check_pins(1536, 6'h3E, 7'h08, 1'b0, "scan_wrap_digit0");
        bus_at(1800, 1'b0, 5'h0C, 32'h0, 4'hF, 32'h0000_0011);
        check_pins(1920, 6'h3D, 7'h79, 1'b1, "scan_digit1");

        // PWM: bright 0x40 lights slots 0..63 only
        bus_at(2000, 1'b1, 5'h00, 32'h0000_4003, 4'hF, 32'h0);
        check_pins(2048, 6'h3B, 7'h24, 1'b1, "pwm40_slot0");
        check_pins(2111, 6'h3B, 7'h24, 1'b1, "pwm40_slot63");
        check_pins(2112, 6'h3F, 7'h7F, 1'b1, "pwm40_slot64");
        bus_at(2320, 1'b1, 5'h00, 32'h0000_0003, 4'hF, 32'h0);
        check_pins(2560, 6'h3F, 7'h7F, 1'b1, "pwm00_slot0");
        check_pins(2600, 6'h3F, 7'h7F, 1'b1, "pwm00_slot40");
        bus_at(2620, 1'b1, 5'h00, 32'h0000_FF03, 4'hF, 32'h0);
        check_pins(2816, 6'h1F, 7'h12, 1'b1, "pwmff_slot0");
        check_pins(3071, 6'h1F, 7'h12, 1'b1, "pwmff_slot255");

        // Blink digit 0
        bus_at(3080, 1'b1, 5'h08, 32'h0000_0001, 4'hF, 32'h0);
        bus_at(3090, 1'b0, 5'h08, 32'h0, 4'hF, 32'h0000_0001);
        check_pins(3200, 6'h3E, 7'h08, 1'b0, "blink_phase0_lit");
        check_pins(4700, 6'h3F, 7'h7F, 1'b1, "blink_phase1_dark");
        check_pins(5000, 6'h3D, 7'h79, 1'b1, "blink_other_digit");

        // Single byte lane write: only digit 1 changes to 6
        bus_at(5200, 1'b1, 5'h10, 32'hFFFF_06FF, 4'b0010, 32'h0);
        bus_now(1'b0, 5'h10, 32'h0, 4'hF, 32'h0302_068A);
        bus_now(1'b0, 5'h14, 32'h0, 4'hF, 32'h0000_0504);
        check_pins(6500, 6'h3D, 7'h02, 1'b1, "byte_lane_digit1");

        // Raw segment mode, then disable the display
        bus_at(6560, 1'b1, 5'h00, 32'h0000_FF01, 4'hF, 32'h0);
        check_pins(6700, 6'h3B, 7'h7D, 1'b1, "raw_digit2");
        check_pins(6720, 6'h3B, 7'h7D, 1'b1, "raw_before_disable");
        bus_at(6721, 1'b1, 5'h00, 32'h0000_FF00, 4'hF, 32'h0);
        check_pins(6730, 6'h3F, 7'h7F, 1'b1, "disabled_dark");
        bus_at(6800, 1'b0, 5'h0C, 32'h0, 4'hF, 32'h0000_0012);
        bus_now(1'b0, 5'h00, 32'h0, 4'hF, 32'h0000_FF00);

        // Reset mid-scan with a bus request pending
        wait_until(6900);
        rst_n  = 1'b0;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = 5'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_pins("reset_midscan");
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        rst_n  = 1'b1;
        for (int w = 0; w < 8; w++)
            bus_now(1'b0, 5'(w * 4), 32'h0, 4'hF, 32'h0);
        check_pins(50, 6'h3F, 7'h7F, 1'b1, "after_reset_dark");

        repeat (4) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL outstanding: %0d responses never acked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
